// File: rtl/bus_arbiter.sv
// bus_arbiter: grants the shared system bus to either the CPU or a DMA master.
// The DMA master takes the bus one edge after it requests it, as long as no
// interrupt-vector fetch is in progress. It keeps the bus for at most
// MAX_BURST cycles. A single RETURN cycle always gives the bus back to the CPU
// before the DMA master can take it again.
module bus_arbiter #(
    parameter int MAX_BURST = 4    // max consecutive DMA cycles, 1..15
) (
    input  logic        MCLK,
    input  logic        reset,

    input  logic [15:0] cpu_MAB,
    input  logic [15:0] cpu_MDBout,
    input  logic        cpu_BW,
    input  logic        cpu_MW,

    input  logic        INTACK,

    input  logic        dma_req,
    input  logic [15:0] dma_MAB,
    input  logic [15:0] dma_MDBout,
    input  logic        dma_BW,
    input  logic        dma_MW,

    output logic [15:0] MAB,
    output logic [15:0] MDBout,
    output logic        BW,
    output logic        MW,

    output logic        dma_gnt,
    output logic        cpu_stall,
    output logic [15:0] dma_cycles
);

    typedef enum logic [1:0] {
        ST_CPU    = 2'b00,
        ST_DMA    = 2'b01,
        ST_RETURN = 2'b10,
        ST_UNUSED = 2'b11
    } state_t;

    // Last burst count value before the DMA master must give up the bus.
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  burst_reg;
    logic [3:0]  burst_next;
    logic [15:0] dma_cycles_reg;
    logic [15:0] dma_cycles_next;

    logic        sel_dma;
    logic [15:0] bus_data;
    logic        bus_bw;
    logic        bus_mw;

    // State, burst counter and DMA-cycle statistic registers. Reset is
    // asynchronous so that a burst is abandoned without waiting for a clock.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_CPU;
            burst_reg      <= 4'd0;
            dma_cycles_reg <= 16'h0000;
        end else begin
            state_reg      <= state_next;
            burst_reg      <= burst_next;
            dma_cycles_reg <= dma_cycles_next;
        end
    end

    // Next-state logic. The burst counter is 0 whenever the FSM is outside DMA.
    // Inside DMA it counts the cycles of the burst that have already completed.
    always_comb begin
        state_next = ST_CPU;
        burst_next = 4'd0;
        case (state_reg)
            ST_CPU: begin
                // INTACK protects the vector fetch. The request then waits.
                if (dma_req && !INTACK) begin
                    state_next = ST_DMA;
                end
            end
            ST_DMA: begin
                // A dropped request and an exhausted burst both leave DMA the
                // same way.
                if (!dma_req || (burst_reg == BURST_LAST)) begin
                    state_next = ST_RETURN;
                end else begin
                    state_next = ST_DMA;
                    burst_next = burst_reg + 4'd1;
                end
            end
            ST_RETURN: begin
                state_next = ST_CPU;
            end
            default: begin
                state_next = ST_CPU;
            end
        endcase
    end

    // Saturating count of every cycle spent in DMA.
    always_comb begin
        dma_cycles_next = dma_cycles_reg;
        if ((state_reg == ST_DMA) && (dma_cycles_reg != 16'hFFFF)) begin
            dma_cycles_next = dma_cycles_reg + 16'd1;
        end
    end

    // Grant and stall are decoded from the state register only. This keeps
    // dma_req off any combinational path to the outputs.
    assign sel_dma    = (state_reg == ST_DMA);
    assign dma_gnt    = sel_dma;
    assign cpu_stall  = sel_dma;
    assign dma_cycles = dma_cycles_reg;

    // Bus owner mux.
    assign MAB      = sel_dma ? dma_MAB    : cpu_MAB;
    assign bus_data = sel_dma ? dma_MDBout : cpu_MDBout;
    assign bus_bw   = sel_dma ? dma_BW     : cpu_BW;
    assign bus_mw   = sel_dma ? dma_MW     : cpu_MW;
    assign BW       = bus_bw;
    assign MW       = bus_mw;

    // Write-data lanes. A read drives all zeros. A byte write clears the
    // upper lane so that stale upper data never reaches the bus.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_lane
            if (gi < 8) begin : g_low
                assign MDBout[gi] = bus_mw & bus_data[gi];
            end else begin : g_high
                assign MDBout[gi] = bus_mw & ~bus_bw & bus_data[gi];
            end
        end
    endgenerate

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus random traffic for bus_arbiter.
// A behavioural model tracks bus ownership as a run length of DMA cycles.
module tb_bus_arbiter;

    localparam int MAX_BURST = 4;

    logic        MCLK = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] cpu_MAB = 16'h0000;
    logic [15:0] cpu_MDBout = 16'h0000;
    logic        cpu_BW = 1'b0;
    logic        cpu_MW = 1'b0;
    logic        INTACK = 1'b0;
    logic        dma_req = 1'b0;
    logic [15:0] dma_MAB = 16'h0000;
    logic [15:0] dma_MDBout = 16'h0000;
    logic        dma_BW = 1'b0;
    logic        dma_MW = 1'b0;
    logic [15:0] MAB;
    logic [15:0] MDBout;
    logic        BW;
    logic        MW;
    logic        dma_gnt;
    logic        cpu_stall;
    logic [15:0] dma_cycles;

    int tests = 0;
    int fails = 0;

    // Model state:
    // - m_dma:   the DMA master owns the bus.
    // - m_gap:   this is the mandatory CPU cycle that follows a burst.
    // - m_run:   the number of DMA cycles already used in the burst.
    // - m_total: the saturating total of DMA cycles.
    bit m_dma = 1'b0;
    bit m_gap = 1'b0;
    int m_run = 0;
    int m_total = 0;

    bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .MCLK(MCLK), .reset(reset),
        .cpu_MAB(cpu_MAB), .cpu_MDBout(cpu_MDBout), .cpu_BW(cpu_BW), .cpu_MW(cpu_MW),
        .INTACK(INTACK),
        .dma_req(dma_req), .dma_MAB(dma_MAB), .dma_MDBout(dma_MDBout),
        .dma_BW(dma_BW), .dma_MW(dma_MW),
        .MAB(MAB), .MDBout(MDBout), .BW(BW), .MW(MW),
        .dma_gnt(dma_gnt), .cpu_stall(cpu_stall), .dma_cycles(dma_cycles)
    );

    always #10 MCLK = ~MCLK;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: update ownership on every edge from the sampled inputs.
    always @(posedge MCLK or posedge reset) begin
        if (reset) begin
            m_dma = 1'b0; m_gap = 1'b0; m_run = 0; m_total = 0;
        end else if (m_dma) begin
            if (m_total < 65535) m_total++;
            m_run++;
            if (!dma_req || m_run == MAX_BURST) begin
                m_dma = 1'b0; m_gap = 1'b1; m_run = 0;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (dma_req && !INTACK) begin
            m_dma = 1'b1; m_run = 0;
        end
    end

    // Compare process: every falling edge outside reset, check all outputs.
    always @(negedge MCLK) begin
        logic [15:0] e_mab, e_data, e_mdb;
        logic        e_bw, e_mw;
        if (!reset) begin
            e_mab  = m_dma ? dma_MAB    : cpu_MAB;
            e_data = m_dma ? dma_MDBout : cpu_MDBout;
            e_bw   = m_dma ? dma_BW     : cpu_BW;
            e_mw   = m_dma ? dma_MW     : cpu_MW;
            if (!e_mw)     e_mdb = 16'h0000;
            else if (e_bw) e_mdb = {8'h00, e_data[7:0]};
            else           e_mdb = e_data;
            check("gnt",    {15'd0, dma_gnt},   {15'd0, m_dma});
            check("stall",  {15'd0, cpu_stall}, {15'd0, m_dma});
            check("mab",    MAB, e_mab);
            check("mdb",    MDBout, e_mdb);
            check("bw",     {15'd0, BW}, {15'd0, e_bw});
            check("mw",     {15'd0, MW}, {15'd0, e_mw});
            check("cycles", dma_cycles, 16'(m_total));
        end
    end

    // One cycle: wait for the edge, then allow 2 time units before new inputs.
    task automatic tick();
        @(posedge MCLK);
        #2;
    endtask

    task automatic drain();
        dma_req = 1'b0;
        INTACK  = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        logic [9:0] exp_pat;

        // Scenario 1: reset state, CPU inputs on the bus.
        cpu_MAB = 16'hF800; cpu_MW = 1'b0; cpu_MDBout = 16'h1357;
        #1 reset = 1'b1;
        #4;
        check("s1_mab",    MAB, 16'hF800);
        check("s1_mdb",    MDBout, 16'h0000);
        check("s1_gnt",    {15'd0, dma_gnt}, 16'h0000);
        check("s1_cycles", dma_cycles, 16'h0000);
        repeat (2) @(posedge MCLK);
        #2 reset = 1'b0;
        $display("[TB] scenario 1 reset state done");

        // Scenario 2: dma_req held for 10 cycles.
        exp_pat = 10'b0111100111;
        tick(); dma_req = 1'b1;
        #1 check("s2_gnt", {15'd0, dma_gnt}, {15'd0, exp_pat[9]});
        for (int i = 1; i < 10; i++) begin
            tick();
            #1 check("s2_gnt", {15'd0, dma_gnt}, {15'd0, exp_pat[9-i]});
        end
        tick(); dma_req = 1'b0;
        #1 check("s2_cycles", dma_cycles, 16'd7);
        drain();
        $display("[TB] scenario 2 burst pattern done");

        // Scenario 3: a two-cycle DMA byte write.
        cpu_MAB = 16'h1234; cpu_MDBout = 16'h5555; cpu_MW = 1'b0; cpu_BW = 1'b0;
        dma_MAB = 16'h0200; dma_MDBout = 16'hABCD; dma_MW = 1'b1; dma_BW = 1'b1;
        tick(); dma_req = 1'b1;
        #1 check("s3_gnt_cpu", {15'd0, dma_gnt}, 16'h0000);
        tick();
        #1 check("s3_mab1", MAB, 16'h0200);
        check("s3_mdb1", MDBout, 16'h00CD);
        check("s3_mw1",  {15'd0, MW}, 16'h0001);
        tick(); dma_req = 1'b0;
        #1 check("s3_mab2", MAB, 16'h0200);
        check("s3_mdb2", MDBout, 16'h00CD);
        check("s3_mw2",  {15'd0, MW}, 16'h0001);
        tick();
        #1 check("s3_ret_gnt", {15'd0, dma_gnt}, 16'h0000);
        check("s3_ret_mw",  {15'd0, MW}, 16'h0000);
        check("s3_ret_mab", MAB, 16'h1234);
        drain();
        $display("[TB] scenario 3 byte write done");

        // Scenario 4: INTACK blocks the grant.
        tick(); dma_req = 1'b1; INTACK = 1'b1;
        #1 check("s4_gnt", {15'd0, dma_gnt}, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            #1 check("s4_gnt", {15'd0, dma_gnt}, 16'h0000);
            check("s4_mab", MAB, 16'h1234);
        end
        tick(); INTACK = 1'b0;
        #1 check("s4_gnt_fall", {15'd0, dma_gnt}, 16'h0000);
        tick();
        #1 check("s4_gnt_after", {15'd0, dma_gnt}, 16'h0001);
        drain();
        $display("[TB] scenario 4 INTACK blocking done");

        // Scenario 5: asynchronous reset in the middle of a burst.
        tick(); dma_req = 1'b1;
        tick();
        #1 check("s5_gnt_c1", {15'd0, dma_gnt}, 16'h0001);
        tick();
        #1 check("s5_burst_pre", {12'd0, dut.burst_reg}, 16'h0001);
        reset = 1'b1;
        #1 check("s5_gnt", {15'd0, dma_gnt}, 16'h0000);
        check("s5_stall",  {15'd0, cpu_stall}, 16'h0000);
        check("s5_mab",    MAB, 16'h1234);
        check("s5_burst",  {12'd0, dut.burst_reg}, 16'h0000);
        check("s5_cycles", dma_cycles, 16'h0000);
        #1 reset = 1'b0;
        tick();
        #1 check("s5_regrant", {15'd0, dma_gnt}, 16'h0001);
        drain();
        $display("[TB] scenario 5 reset abort done");

        // Scenario 6: the DMA cycle count saturates at 0xFFFF.
        tick();
        force dut.dma_cycles_reg = 16'hFFFE;
        m_total = 65534;
        #1 release dut.dma_cycles_reg;
        #1 check("s6_preload", dma_cycles, 16'hFFFE);
        tick(); dma_req = 1'b1;
        tick();
        tick();
        tick(); dma_req = 1'b0;
        drain();
        #1 check("s6_sat", dma_cycles, 16'hFFFF);
        $display("[TB] scenario 6 saturation done");

        // Random traffic, with occasional asynchronous reset pulses.
        for (int n = 0; n < 2000; n++) begin
            tick();
            dma_req    = ($urandom_range(0, 99) < 60);
            INTACK     = ($urandom_range(0, 99) < 15);
            cpu_MAB    = 16'($urandom);
            cpu_MDBout = 16'($urandom);
            cpu_BW     = 1'($urandom);
            cpu_MW     = 1'($urandom);
            dma_MAB    = 16'($urandom);
            dma_MDBout = 16'($urandom);
            dma_BW     = 1'($urandom);
            dma_MW     = 1'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end
        $display("[TB] random phase done");

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The parameter list SHALL be: MAX_BURST, 4, maximum consecutive DMA-owned bus cycles (legal range 1..15).
REQ-002 The clock and reset ports SHALL be: MCLK  input  1  system clock (all state changes on rising edge); reset  input  1  asynchronous, active-high reset.
REQ-003 The CPU bus inputs SHALL be: cpu_MAB  input  16  CPU address; cpu_MDBout  input  16  CPU write data; cpu_BW  input  1  CPU byte/word; cpu_MW  input  1  CPU write enable.
REQ-004 The interrupt input SHALL be: INTACK  input  1  CPU interrupt-vector fetch in progress.
REQ-005 The DMA request inputs SHALL be: dma_req  input  1  DMA bus request (level); dma_MAB  input  16  DMA address; dma_MDBout  input  16  DMA write data; dma_BW  input  1  DMA byte/word; dma_MW  input  1  DMA write enable.
REQ-006 The system bus outputs SHALL be: MAB  output  16  system address; MDBout  output  16  system write data; BW  output  1  system byte/word; MW  output  1  system write enable.
REQ-007 The status outputs SHALL be: dma_gnt  output  1  DMA owns bus this cycle; cpu_stall  output  1  CPU must hold state; dma_cycles  output  16  saturating count of DMA-owned cycles.

Function
REQ-008 The FSM SHALL have three registered states: CPU (00), DMA (01), RETURN (10); code 11 SHALL transition to CPU.
REQ-009 CPU->DMA SHALL occur at a rising edge when dma_req=1 and INTACK=0, so grant latency is exactly 1 cycle from dma_req.
REQ-010 INTACK=1 SHALL block CPU->DMA for that edge, regardless of dma_req.
REQ-011 In DMA, a 4-bit burst counter SHALL increment each cycle, starting at 0 on entry.
REQ-012 DMA->RETURN SHALL occur when dma_req=0 or when the burst counter equals MAX_BURST-1; the first condition has priority only in that both exit identically.
REQ-013 RETURN SHALL last exactly one cycle and then go to CPU, which guarantees the CPU at least one bus cycle between DMA bursts.
REQ-014 A dma_req held high through RETURN SHALL re-enter DMA after one CPU-state edge, unless INTACK=1.
REQ-015 dma_gnt and cpu_stall SHALL be 1 iff state=DMA, decoded from the state register only with no combinational path from dma_req.
REQ-016 When state=DMA, MAB/MDBout/BW/MW SHALL equal dma_MAB/dma_MDBout/dma_BW/dma_MW; otherwise they SHALL equal the cpu_* inputs.
REQ-017 When MW=0, MDBout SHALL be 0x0000.
REQ-018 When MW=1 and BW=1, MDBout SHALL be {8'h00, data[7:0]}.
REQ-019 dma_cycles SHALL increment by 1 per DMA-state cycle and saturate at 0xFFFF, with no wrap.
REQ-020 The burst counter SHALL clear on every exit from DMA.

Reset
REQ-021 Asserting reset SHALL immediately force state=CPU, burst counter=0, dma_cycles=0x0000, dma_gnt=0 and cpu_stall=0, so the bus muxes the CPU inputs.
REQ-022 Reset asserted mid-burst SHALL abort the burst; the partially issued DMA transfer SHALL be discarded with no RETURN cycle.
REQ-023 After reset deasserts, the first CPU->DMA transition SHALL require a rising edge with dma_req=1 and INTACK=0.

Verification
REQ-024 Scenario 1: reset, cpu_MAB=0xF800, cpu_MW=0, dma_req=0 -> MAB=0xF800, MDBout=0x0000, dma_gnt=0, dma_cycles=0.
REQ-025 Scenario 2: dma_req=1 held for 10 cycles, MAX_BURST=4 -> dma_gnt pattern 0,1,1,1,1,0(RETURN),0(CPU),1,1,1, dma_cycles=7.
REQ-026 Scenario 3: dma_req=1 for 2 cycles, dma_MAB=0x0200, dma_MW=1, dma_BW=1, dma_MDBout=0xABCD -> MAB=0x0200, MDBout=0x00CD, MW=1 for exactly 2 cycles, then RETURN.
REQ-027 Scenario 4: dma_req=1 with INTACK=1 for 3 cycles -> dma_gnt=0 for those cycles, MAB=cpu_MAB; dma_gnt=1 one edge after INTACK falls.
REQ-028 Scenario 5: reset pulsed in the 2nd cycle of a DMA burst -> dma_gnt falls without waiting for MCLK, MAB=cpu_MAB, burst counter=0.
REQ-029 Scenario 6: force dma_cycles to 0xFFFE, run a 3-cycle burst -> dma_cycles=0xFFFF, no wrap.
